// File: rtl/pulse_stretcher_pkg.sv
// -----------------------------------------------------------------------------
// pulse_stretcher_pkg
// Shared definitions for the pulse stretcher: FSM state encoding, default
// timing constants and a helper that sizes the shared hold/gap timer.
// -----------------------------------------------------------------------------
package pulse_stretcher_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        HOLD = 2'b01,
        GAP  = 2'b10
    } state_t;

    localparam int unsigned DEF_HOLD_CYCLES = 32'd4;
    localparam int unsigned DEF_GAP_CYCLES  = 32'd2;
    localparam int unsigned DEF_PEND_W      = 32'd3;

    // Bits needed to hold the larger of the two reload values (cycles-1).
    function automatic int unsigned timer_width(input int unsigned h, input int unsigned g);
        int unsigned m;
        m = (h > g) ? h : g;
        if (m <= 32'd2) begin
            return 32'd1;
        end else begin
            return $clog2(m);
        end
    endfunction

endpackage

// File: rtl/pulse_stretcher_timer.sv
// -----------------------------------------------------------------------------
// stretch_timer
// Loadable down-counter shared by the HOLD and GAP phases. A load strobe
// copies load_val into the counter; otherwise it counts down and parks at 0.
// expire is high while the count is 0.
//
// Ports:
//   CLK       rising-edge clock
//   RST       asynchronous active-low reset (count cleared to 0)
//   load      load strobe (priority over counting)
//   load_val  value loaded on the strobe
//   expire    count == 0
// -----------------------------------------------------------------------------
module stretch_timer #(
    parameter int unsigned W = 32'd2
) (
    input  logic         CLK,
    input  logic         RST,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic         expire
);

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    // Next count: load wins, otherwise decrement until parked at zero.
    always_comb begin
        count_d = count_q;
        if (load) begin
            count_d = load_val;
        end else if (count_q != {W{1'b0}}) begin
            count_d = count_q - W'(1'b1);
        end else begin
            count_d = count_q;
        end
    end

    // Counter register.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            count_q <= {W{1'b0}};
        end else begin
            count_q <= count_d;
        end
    end

    assign expire = (count_q == {W{1'b0}});

endmodule

// File: rtl/pulse_stretcher.sv
// -----------------------------------------------------------------------------
// pulse_stretcher
// Turns single-cycle active-high event pulses into held active-low presses:
// each event holds button_out low for HOLD_CYCLES, followed by at least
// GAP_CYCLES high. Events arriving while a press/gap is running are queued in
// a saturating pending counter; a dropped event sets the sticky overflow flag.
//
// Ports:
//   CLK         rising-edge clock
//   RST         asynchronous active-low reset
//   pulse_in    active-high event, one event per high cycle
//   button_out  active-low stretched press (registered)
//   busy        high in HOLD or GAP (registered)
//   pend_cnt    queued events not yet emitted (registered)
//   overflow    sticky drop indicator, cleared only by reset (registered)
//
// Build option PULSE_STRETCHER_RETRIGGER_EN: an event during HOLD restarts the
// hold time instead of being queued. Events during GAP still queue.
// -----------------------------------------------------------------------------
module pulse_stretcher
    import pulse_stretcher_pkg::*;
#(
    parameter int unsigned HOLD_CYCLES = DEF_HOLD_CYCLES,
    parameter int unsigned GAP_CYCLES  = DEF_GAP_CYCLES,
    parameter int unsigned PEND_W      = DEF_PEND_W
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              pulse_in,
    output logic              button_out,
    output logic              busy,
    output logic [PEND_W-1:0] pend_cnt,
    output logic              overflow
);

    localparam int unsigned TW = timer_width(HOLD_CYCLES, GAP_CYCLES);
    localparam logic [TW-1:0] HOLD_LOAD = TW'(HOLD_CYCLES - 32'd1);
    localparam logic [TW-1:0] GAP_LOAD  = TW'(GAP_CYCLES - 32'd1);

    state_t             state_q;
    state_t             state_d;
    logic [PEND_W-1:0]  pend_q;
    logic [PEND_W-1:0]  pend_d;
    logic               overflow_q;
    logic               overflow_d;
    logic               button_q;
    logic               button_d;
    logic               busy_q;
    logic               busy_d;

    logic               t_load_s;
    logic [TW-1:0]      t_val_s;
    logic               t_expire_s;
    logic               enq_s;
    logic               deq_s;

    stretch_timer #(
        .W (TW)
    ) u_timer (
        .CLK      (CLK),
        .RST      (RST),
        .load     (t_load_s),
        .load_val (t_val_s),
        .expire   (t_expire_s)
    );

    // Next-state, timer control and queue bookkeeping.
    always_comb begin
        state_d    = state_q;
        pend_d     = pend_q;
        overflow_d = overflow_q;
        t_load_s   = 1'b0;
        t_val_s    = HOLD_LOAD;
        enq_s      = 1'b0;
        deq_s      = 1'b0;

        case (state_q)
            IDLE: begin
                if (pulse_in) begin
                    state_d  = HOLD;
                    t_load_s = 1'b1;
                    t_val_s  = HOLD_LOAD;
                end else begin
                    state_d  = IDLE;
                end
            end
            HOLD: begin
`ifdef PULSE_STRETCHER_RETRIGGER_EN
                // A new event restarts the hold, even on the expiring cycle.
                if (pulse_in) begin
                    state_d  = HOLD;
                    t_load_s = 1'b1;
                    t_val_s  = HOLD_LOAD;
                end else if (t_expire_s) begin
                    state_d  = GAP;
                    t_load_s = 1'b1;
                    t_val_s  = GAP_LOAD;
                end else begin
                    state_d  = HOLD;
                end
`else
                enq_s = pulse_in;
                if (t_expire_s) begin
                    state_d  = GAP;
                    t_load_s = 1'b1;
                    t_val_s  = GAP_LOAD;
                end else begin
                    state_d  = HOLD;
                end
`endif
            end
            GAP: begin
                if (t_expire_s) begin
                    if (pend_q != {PEND_W{1'b0}}) begin
                        // Oldest queued event starts the next press; a
                        // simultaneous new event takes its place in the queue.
                        state_d  = HOLD;
                        t_load_s = 1'b1;
                        t_val_s  = HOLD_LOAD;
                        deq_s    = 1'b1;
                        enq_s    = pulse_in;
                    end else if (pulse_in) begin
                        state_d  = HOLD;
                        t_load_s = 1'b1;
                        t_val_s  = HOLD_LOAD;
                    end else begin
                        state_d  = IDLE;
                    end
                end else begin
                    state_d = GAP;
                    enq_s   = pulse_in;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Pending counter: a consume paired with an enqueue cancels out.
        if (enq_s && deq_s) begin
            pend_d = pend_q;
        end else if (deq_s) begin
            pend_d = pend_q - PEND_W'(1'b1);
        end else if (enq_s) begin
            if (pend_q == {PEND_W{1'b1}}) begin
                overflow_d = 1'b1;
            end else begin
                pend_d = pend_q + PEND_W'(1'b1);
            end
        end else begin
            pend_d = pend_q;
        end

        button_d = (state_d != HOLD);
        busy_d   = (state_d != IDLE);
    end

    // State, queue and output registers.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q    <= IDLE;
            pend_q     <= {PEND_W{1'b0}};
            overflow_q <= 1'b0;
            button_q   <= 1'b1;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            pend_q     <= pend_d;
            overflow_q <= overflow_d;
            button_q   <= button_d;
            busy_q     <= busy_d;
        end
    end

    assign button_out = button_q;
    assign busy       = busy_q;
    assign pend_cnt   = pend_q;
    assign overflow   = overflow_q;

endmodule

// File: tb/tb_pulse_stretcher.sv
// -----------------------------------------------------------------------------
// tb_pulse_stretcher
// Directed scenarios plus randomized traffic against a cycle-offset model of
// the stretcher (press position measured from its start, integer queue).
// A falling-edge detector on button_out stands in for the button shaper.
// -----------------------------------------------------------------------------
module tb_pulse_stretcher;

    localparam int H    = 4;
    localparam int G    = 2;
    localparam int PW   = 3;
    localparam int PMAX = 7;

    logic          CLK      = 1'b0;
    logic          RST      = 1'b0;
    logic          pulse_in = 1'b0;
    logic          button_out;
    logic          busy;
    logic [PW-1:0] pend_cnt;
    logic          overflow;

    int checks   = 0;
    int failures = 0;
    string scen  = "reset";

    // Reference model: m_t counts cycles since the current press started.
    int m_active, m_t, m_pend, m_ovf;
    int m_started = 0;
    int m_events  = 0;
    int m_dropped = 0;

    // Shaper stand-in: one pulse per high-to-low transition of button_out.
    logic shaper_prev = 1'b1;
    int   shaper_cnt  = 0;

    always #5 CLK = ~CLK;

    pulse_stretcher #(
        .HOLD_CYCLES (H),
        .GAP_CYCLES  (G),
        .PEND_W      (PW)
    ) dut (
        .CLK        (CLK),
        .RST        (RST),
        .pulse_in   (pulse_in),
        .button_out (button_out),
        .busy       (busy),
        .pend_cnt   (pend_cnt),
        .overflow   (overflow)
    );

    always @(negedge CLK) begin
        shaper_prev <= button_out;
        if (shaper_prev === 1'b1 && button_out === 1'b0) begin
            shaper_cnt <= shaper_cnt + 1;
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks = checks + 1;
        if (obs !== exp) begin
            failures = failures + 1;
            $display("FAIL [%s] %s: got %0d expected %0d at %0t", scen, tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_active = 0;
        m_t      = 0;
        m_pend   = 0;
        m_ovf    = 0;
    endtask

    task automatic model_queue(input int p);
        if (p != 0) begin
            if (m_pend == PMAX) begin
                m_ovf     = 1;
                m_dropped = m_dropped + 1;
            end else begin
                m_pend = m_pend + 1;
            end
        end
    endtask

    task automatic model_edge(input int p);
        m_events = m_events + p;
        if (m_active == 0) begin
            if (p != 0) begin
                m_active  = 1;
                m_t       = 0;
                m_started = m_started + 1;
            end
        end else if (m_t == H + G - 1) begin
            // Last gap cycle: start the next press if anything is waiting.
            if (m_pend > 0) begin
                m_pend    = m_pend - 1 + p;
                m_t       = 0;
                m_started = m_started + 1;
            end else if (p != 0) begin
                m_t       = 0;
                m_started = m_started + 1;
            end else begin
                m_active = 0;
            end
        end else begin
`ifdef PULSE_STRETCHER_RETRIGGER_EN
            if (m_t < H && p != 0) begin
                m_t = 0;
            end else begin
                m_t = m_t + 1;
                model_queue(p);
            end
`else
            m_t = m_t + 1;
            model_queue(p);
`endif
        end
    endtask

    task automatic check_outputs();
        check_eq("button_out", 32'(button_out), 32'((m_active != 0 && m_t < H) ? 0 : 1));
        check_eq("busy",       32'(busy),       32'(m_active));
        check_eq("pend_cnt",   32'(pend_cnt),   32'(m_pend));
        check_eq("overflow",   32'(overflow),   32'(m_ovf));
    endtask

    // Called at a falling edge; drives one cycle and checks after the rising edge.
    task automatic step(input int p);
        pulse_in = (p != 0);
        @(posedge CLK);
        model_edge(p);
        #1;
        check_outputs();
        @(negedge CLK);
    endtask

    initial begin
        int sat_max;
        int sh0, ev0, dr0, st0;
        int density;

        // Reset held for three edges, then idle.
        model_reset();
        RST = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(posedge CLK);
            #1;
            check_outputs();
        end
        @(negedge CLK);
        RST = 1'b1;
        scen = "idle";
        for (int i = 0; i < 4; i++) step(0);

        // Single pulse: low for 4 cycles, busy for 6.
        scen = "single";
        step(1);
        for (int i = 0; i < 8; i++) step(0);

        // Back-to-back: second event queued, replayed after the gap.
        scen = "b2b";
        step(1);
        step(0);
        step(1);
`ifndef PULSE_STRETCHER_RETRIGGER_EN
        check_eq("b2b_pend_after_k2", 32'(pend_cnt), 32'd1);
`endif
        for (int i = 0; i < 12; i++) step(0);

        // Saturation: ten held cycles fill the queue and drop an event.
        scen = "saturate";
        sh0 = shaper_cnt; ev0 = m_events; dr0 = m_dropped; st0 = m_started;
        sat_max = 0;
        for (int i = 0; i < 10; i++) begin
            step(1);
            if (int'(pend_cnt) > sat_max) sat_max = int'(pend_cnt);
        end
        for (int i = 0; i < 70; i++) step(0);
`ifndef PULSE_STRETCHER_RETRIGGER_EN
        check_eq("sat_pend_max", 32'(sat_max), 32'(PMAX));
        check_eq("sat_overflow", 32'(overflow), 32'd1);
        check_eq("sat_presses_vs_events", 32'(shaper_cnt - sh0), 32'((m_events - ev0) - (m_dropped - dr0)));
`endif
        check_eq("sat_presses", 32'(shaper_cnt - sh0), 32'(m_started - st0));

        // Asynchronous reset in the middle of a press with an event queued.
        scen = "rst_mid";
        step(1);
        step(1);
        step(0);
        #2;
        RST = 1'b0;
        #1;
        check_eq("rst_button", 32'(button_out), 32'd1);
        check_eq("rst_pend",   32'(pend_cnt),   32'd0);
        check_eq("rst_busy",   32'(busy),       32'd0);
        check_eq("rst_ovf",    32'(overflow),   32'd0);
        model_reset();
        @(posedge CLK);
        @(negedge CLK);
        RST = 1'b1;
        sh0 = shaper_cnt;
        for (int i = 0; i < 12; i++) step(0);
        check_eq("rst_no_resume", 32'(shaper_cnt - sh0), 32'd0);

        // Randomized traffic with varying density; shaper loopback count.
        scen = "random";
        sh0 = shaper_cnt; st0 = m_started;
        density = 10;
        for (int i = 0; i < 600; i++) begin
            if (i % 50 == 0) density = int'($urandom_range(2, 80));
            step(($urandom_range(0, 99) < density) ? 1 : 0);
        end
        for (int i = 0; i < 80; i++) step(0);
        check_eq("loopback_presses", 32'(shaper_cnt - sh0), 32'(m_started - st0));
        check_eq("drained_busy", 32'(busy), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
